// File: rtl/mem_word_reader.sv
// Reads big-endian 32-bit words byte by byte from a synchronous byte memory and
// streams them out over valid/ready, one word at a time.
module mem_word_reader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_OUT, S_FIN} state_t;

    state_t              state_q;
    logic [1:0]          idx_q;
    logic                pend_q;
    logic [ADDR_W-1:0]   word_addr_q;
    logic [CNT_W-1:0]    count_q;
    logic [31:0]         word_q;
    logic                mem_rd_en_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                out_valid_q;
    logic [31:0]         out_data_q;
    logic [ADDR_W-1:0]   out_addr_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;

    logic [ADDR_W-1:0]   rd_addr_d;
    logic [ADDR_W-1:0]   next_word_d;
    logic [31:0]         shift_d;

    always_comb begin
        rd_addr_d   = word_addr_q + ADDR_W'(idx_q) + ADDR_W'(1);
        next_word_d = word_addr_q + ADDR_W'(4);
        shift_d     = {word_q[23:0], mem_rdata};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            word_addr_q <= '0;
            count_q     <= '0;
            word_q      <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            // Memory answers one cycle after the request, so the byte to shift in
            // belongs to the request that was on the port during the previous cycle.
            pend_q  <= mem_rd_en_q;
            if (pend_q) begin
                word_q <= shift_d;
            end

            if (busy_q && abort) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                out_valid_q <= 1'b0;
                mem_rd_en_q <= 1'b0;
                pend_q      <= 1'b0;
                mem_addr_q  <= '0;
                out_data_q  <= '0;
                out_addr_q  <= '0;
            end else begin
                case (state_q)
                    S_RD: begin
                        if (idx_q == 2'd3) begin
                            mem_rd_en_q <= 1'b0;
                            state_q     <= S_CAP;
                        end else begin
                            idx_q      <= idx_q + 2'd1;
                            mem_addr_q <= rd_addr_d;
                        end
                    end
                    S_CAP: begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= shift_d;
                        out_addr_q  <= word_addr_q;
                        state_q     <= S_OUT;
                    end
                    S_OUT: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            count_q     <= count_q - CNT_W'(1);
                            if (count_q == CNT_W'(1)) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_FIN;
                            end else begin
                                word_addr_q <= next_word_d;
                                mem_addr_q  <= next_word_d;
                                mem_rd_en_q <= 1'b1;
                                idx_q       <= '0;
                                state_q     <= S_RD;
                            end
                        end
                    end
                    default: begin
                        // IDLE and FIN both accept a new command: busy is already low.
                        state_q <= S_IDLE;
                        if (start) begin
                            if (base_addr[1:0] != 2'b00) begin
                                error_q <= 1'b1;
                            end else if (word_count == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                word_addr_q <= base_addr;
                                count_q     <= word_count;
                                mem_addr_q  <= base_addr;
                                mem_rd_en_q <= 1'b1;
                                idx_q       <= '0;
                                busy_q      <= 1'b1;
                                state_q     <= S_RD;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_mem_word_reader.sv
// Directed bench for mem_word_reader: byte memory model, transfer monitor and
// hand-computed expectations for streaming, stalls, errors, wrap, abort and reset.
module tb_mem_word_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [7:0]  word_count = '0;
    logic        abort = 1'b0;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [9:0]  out_addr;
    logic        busy;
    logic        done;
    logic        error;

    logic [7:0]  mem [1024];
    logic        rdy_mode = 1'b0;
    logic        rdy_fixed = 1'b1;
    logic        rdy_tog = 1'b0;
    logic        clr_req = 1'b0;
    int          ncyc = 0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          rd_cnt, done_cnt, err_cnt, ov_cnt, stab_err;
    logic [41:0] xq [$];
    logic        hold_q;
    logic [41:0] hold_val;

    assign out_ready = rdy_mode ? rdy_tog : rdy_fixed;

    mem_word_reader #(.ADDR_W(10), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .abort(abort), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        ncyc++;
        rdy_tog = (ncyc % 3 == 0);
    end

    always @(posedge clk) begin
        if (reset || clr_req) begin
            rd_cnt = 0; done_cnt = 0; err_cnt = 0; ov_cnt = 0; stab_err = 0;
            xq.delete();
            hold_q = 1'b0;
        end else begin
            if (mem_rd_en) rd_cnt++;
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (out_valid) ov_cnt++;
            if (hold_q && out_valid && {out_addr, out_data} != hold_val) stab_err++;
            hold_q   = out_valid && !out_ready;
            hold_val = {out_addr, out_data};
            if (out_valid && out_ready) begin
                xq.push_back({out_addr, out_data});
                $display("xfer addr=%0d data=%08h", out_addr, out_data);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        @(negedge clk); clr_req = 1'b1;
        @(negedge clk); clr_req = 1'b0;
    endtask

    task automatic issue(input logic [9:0] b, input logic [7:0] c);
        @(negedge clk);
        base_addr = b; word_count = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int k = 0;
        while (done_cnt == 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(done_cnt != 0), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_words(input string tag, input int n, input logic [9:0] a0,
                               input logic [31:0] d0);
        check({tag, "_nxfer"}, 64'(xq.size()), 64'(n));
        for (int i = 0; i < n && i < xq.size(); i++) begin
            check({tag, "_word"}, 64'(xq[i]), {22'd0, a0 + 10'(4 * i), d0 + 32'(i)});
        end
    endtask

    initial begin
        int lat;
        int k;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[4 * i + 3] = 8'(i + 1);

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {7'd0, mem_rd_en, busy, done, error, out_valid, mem_addr, out_addr, out_data},
              64'd0);
        reset = 1'b0;
        clr();

        // 1: eight words, consumer always ready
        issue(10'd0, 8'd8);
        check("t1_busy", 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t1_latency", 64'(lat), 64'd5);
        wait_done("t1_done", 200);
        check("t1_rdcnt", 64'(rd_cnt), 64'd32);
        check("t1_donecnt", 64'(done_cnt), 64'd1);
        check_words("t1", 8, 10'd0, 32'd1);

        // 2: same load with a stalling consumer
        clr();
        rdy_mode = 1'b1;
        issue(10'd0, 8'd8);
        wait_done("t2_done", 400);
        rdy_mode = 1'b0;
        check("t2_stable", 64'(stab_err), 64'd0);
        check("t2_rdcnt", 64'(rd_cnt), 64'd32);
        check_words("t2", 8, 10'd0, 32'd1);

        // 3: misaligned base
        clr();
        issue(10'd2, 8'd1);
        check("t3_error", 64'(error), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);
        repeat (8) @(negedge clk);
        check("t3_rdcnt", 64'(rd_cnt), 64'd0);
        check("t3_errcnt", 64'(err_cnt), 64'd1);
        check("t3_ovcnt", 64'(ov_cnt), 64'd0);

        // 4: zero count, then a start while busy
        clr();
        issue(10'd0, 8'd0);
        check("t4_done", 64'(done), 64'd1);
        repeat (8) @(negedge clk);
        check("t4_rdcnt", 64'(rd_cnt), 64'd0);
        check("t4_ovcnt", 64'(ov_cnt), 64'd0);
        clr();
        issue(10'd0, 8'd2);
        @(negedge clk);
        issue(10'd8, 8'd5);
        wait_done("t4b_done", 100);
        check("t4b_rdcnt", 64'(rd_cnt), 64'd8);
        check_words("t4b", 2, 10'd0, 32'd1);

        // 5: address wrap
        mem[1020] = 8'hDE; mem[1021] = 8'hAD; mem[1022] = 8'hBE; mem[1023] = 8'hEF;
        clr();
        issue(10'd1020, 8'd2);
        wait_done("t5_done", 100);
        check("t5_nxfer", 64'(xq.size()), 64'd2);
        if (xq.size() == 2) begin
            check("t5_w0", 64'(xq[0]), {22'd0, 10'd1020, 32'hDEADBEEF});
            check("t5_w1", 64'(xq[1]), {22'd0, 10'd0, 32'h00000001});
        end

        // 6a: abort during the read of word 3
        clr();
        issue(10'd0, 8'd8);
        k = 0;
        while (xq.size() < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t6_reach_w3", 64'(xq.size()), 64'd2);
        check("t6_in_rd", 64'(mem_rd_en), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t6_abort_outs", {mem_rd_en, busy, out_valid, done, out_data}, 64'd0);
        repeat (20) @(negedge clk);
        check("t6_abort_nodone", 64'(done_cnt), 64'd0);
        check("t6_abort_nxfer", 64'(xq.size()), 64'd2);

        // 6b: reset while a word is waiting for the consumer
        rdy_fixed = 1'b0;
        issue(10'd0, 8'd2);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t6_out_wait", 64'(out_valid), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_reset_outs",
              {7'd0, mem_rd_en, busy, done, error, out_valid, mem_addr, out_addr, out_data},
              64'd0);
        reset = 1'b0;
        rdy_fixed = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_reset_nodone", 64'(done_cnt), 64'd0);

        // 6c: fresh command after abort/reset
        clr();
        issue(10'd0, 8'd1);
        wait_done("t6c_done", 100);
        check("t6c_rdcnt", 64'(rd_cnt), 64'd4);
        check_words("t6c", 1, 10'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
